traffic_phase_scheduler: RTL
============================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameters, one per line (name, default, meaning) SHALL be:
  GREEN_MIN  4   minimum green, in ticks
  GREEN_MAX  8   maximum green on road B, in ticks
  YELLOW_T   2   yellow duration, in ticks
  ALLRED_T   1   all-red clearance, in ticks
  WALK_T     3   pedestrian walk duration, in ticks
  CW         4   phase-timer width, in bits
REQ-002 Ports, one per line (name, direction, width, meaning) SHALL be:
  clk       in   1  single clock
  reset_n   in   1  asynchronous, active-low reset
  tick      in   1  one-cycle timebase enable
  sa        in   1  road A vehicle sensor (level)
  sb        in   1  road B vehicle sensor (level)
  ped_btn   in   1  pedestrian request (level)
  emg       in   1  emergency preemption request (level)
  emg_dir   in   1  preempted road: 0 = A, 1 = B
  Ra Ya Ga  out  1  road A lamps
  Rb Yb Gb  out  1  road B lamps
  walk      out  1  pedestrian walk lamp
  phase     out  3  current state encoding
REQ-003 Clock and reset SHALL be exactly one clock, clk, and an asynchronous active-low reset, reset_n.

Function
REQ-004 The FSM SHALL have these states and encodings: GA=0, YA=1, ARA=2, GB=3, YB=4, ARB=5, WALK=6, ARW=7; phase SHALL equal the current state.
REQ-005 The timer SHALL clear on every state change, increment on tick otherwise, and saturate at 2^CW-1.
REQ-006 A timed exit SHALL occur only on a clock edge with tick=1 and timer==DUR-1, so that each timed state lasts DUR ticks.
REQ-007 Request latches req_a, req_b and req_p SHALL behave as follows:
  - set while sa, sb or ped_btn respectively is high;
  - req_a cleared on entry to GA; req_b cleared on entry to GB; req_p cleared on entry to WALK;
  - a set request and a clear in the same cycle SHALL resolve to clear.
REQ-008 GA SHALL go to YA when timer>=GREEN_MIN-1 and tick=1 and (req_b or req_p); with no demand, GA SHALL rest indefinitely.
REQ-009 GB SHALL go to YB when tick=1 and either (timer>=GREEN_MIN-1 and (req_a or req_p)) or timer==GREEN_MAX-1.
REQ-010 YA SHALL go to ARA, and YB to ARB, after YELLOW_T ticks.
REQ-011 After ALLRED_T ticks, ARA SHALL go to WALK if req_p, else to GB; ARB SHALL go to WALK if req_p, else to GA.
REQ-012 A last_road register SHALL record A or B on entry to ARA or ARB respectively.
REQ-013 WALK SHALL go to ARW after WALK_T ticks; ARW SHALL go, after ALLRED_T ticks, to GB if last_road=A, else to GA.
REQ-014 Emergency preemption SHALL take priority over REQ-008 to REQ-013 as follows:
  - emg=1 with green on the non-preempted road: move to that road's yellow on the next edge, ignoring GREEN_MIN and tick;
  - emg=1 in WALK: move to ARW on the next edge;
  - emg=1 leaving ARA, ARB or ARW: go to the emg_dir green, skipping WALK;
  - emg=1 in the emg_dir green: hold there, with no exit;
  - yellow and all-red durations are never shortened.
REQ-015 Outputs SHALL be a Moore decode of state:
  - Ga in GA; Ya in YA; Ra in all other states;
  - Gb in GB; Yb in YB; Rb in all other states;
  - walk in WALK only.
REQ-016 At most one of Gb/Yb SHALL be asserted together with Ga/Ya never, and walk=1 SHALL imply Ra=Rb=1, in every cycle.

Reset
REQ-017 When reset_n=0, the block SHALL immediately enter state GA, with timer=0, all request latches=0 and last_road=A; outputs SHALL then be Ga=1, Rb=1 and all others 0.
REQ-018 Reset asserted mid-phase, including during WALK or preemption, SHALL abort to the REQ-017 values with no intermediate yellow.

Verification
REQ-019 The bench SHALL cover these scenarios, with tick=1 every cycle and default parameters:
  - No inputs for 50 cycles after reset -> phase stays 0; Ga=1, Rb=1 throughout.
  - sb pulsed 1 cycle at cycle 0 -> GA for 4 cycles, YA for 2, ARA for 1, GB for 8 (no req_a), then YB.
  - ped_btn pulsed during GA, sb=0 -> GA, YA, ARA, WALK (3 cycles, walk=1, Ra=Rb=1), ARW, GB.
  - emg=1, emg_dir=B asserted at GA timer=1 -> YA on the next edge, then ARA, then GB held while emg=1, with req_p ignored.
  - reset_n dropped during WALK -> same-cycle phase=0, walk=0, Ga=1; req_p clear.
  - sa and sb both held high -> alternating GA(4)/GB(4) service; the REQ-016 invariant holds for every cycle.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road traffic light phase FSM with pedestrian walk and emergency preemption
module traffic_phase_scheduler #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 8,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 3,
   parameter int CW        = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       sa,
   input  logic       sb,
   input  logic       ped_btn,
   input  logic       emg,
   input  logic       emg_dir,
   output logic       Ra,
   output logic       Ya,
   output logic       Ga,
   output logic       Rb,
   output logic       Yb,
   output logic       Gb,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_GA   = 3'd0,
      S_YA   = 3'd1,
      S_ARA  = 3'd2,
      S_GB   = 3'd3,
      S_YB   = 3'd4,
      S_ARB  = 3'd5,
      S_WALK = 3'd6,
      S_ARW  = 3'd7
   } state_t;

   localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] AR_M1   = CW'(ALLRED_T - 1);
   localparam logic [CW-1:0] WALK_M1 = CW'(WALK_T - 1);
   localparam logic [CW-1:0] T_SAT   = '1;

   state_t          state_q, state_d;
   logic [CW-1:0]   timer_q, timer_d;
   logic            req_a_q, req_a_d;
   logic            req_b_q, req_b_d;
   logic            req_p_q, req_p_d;
   logic            last_road_q, last_road_d;   // 0 = road A, 1 = road B

   logic            min_done;
   logic            yel_done;
   logic            ar_done;
   logic            walk_done;
   state_t          emg_green;

   always_comb begin
      state_d   = state_q;
      min_done  = tick && (timer_q >= GMIN_M1);
      yel_done  = tick && (timer_q == YEL_M1);
      ar_done   = tick && (timer_q == AR_M1);
      walk_done = tick && (timer_q == WALK_M1);
      emg_green = emg_dir ? S_GB : S_GA;

      case (state_q)
         S_GA: begin
            // Preemption toward B forces yellow at once; preemption toward A pins green.
            if (emg) begin
               if (emg_dir) state_d = S_YA;
            end else if (min_done && (req_b_q || req_p_q)) begin
               state_d = S_YA;
            end
         end
         S_YA:  if (yel_done) state_d = S_ARA;
         S_ARA: begin
            if (ar_done) begin
               if (emg)          state_d = emg_green;
               else if (req_p_q) state_d = S_WALK;
               else              state_d = S_GB;
            end
         end
         S_GB: begin
            if (emg) begin
               if (!emg_dir) state_d = S_YB;
            end else if ((min_done && (req_a_q || req_p_q)) ||
                         (tick && (timer_q == GMAX_M1))) begin
               state_d = S_YB;
            end
         end
         S_YB:  if (yel_done) state_d = S_ARB;
         S_ARB: begin
            if (ar_done) begin
               if (emg)          state_d = emg_green;
               else if (req_p_q) state_d = S_WALK;
               else              state_d = S_GA;
            end
         end
         S_WALK: if (emg || walk_done) state_d = S_ARW;
         S_ARW: begin
            if (ar_done) begin
               if (emg)              state_d = emg_green;
               else if (last_road_q) state_d = S_GA;
               else                  state_d = S_GB;
            end
         end
      endcase
   end

   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q)              timer_d = '0;
      else if (tick && (timer_q != T_SAT)) timer_d = timer_q + CW'(1);

      // A clear on phase entry wins over a sensor held high in the same cycle.
      req_a_d = req_a_q | sa;
      req_b_d = req_b_q | sb;
      req_p_d = req_p_q | ped_btn;
      if ((state_d == S_GA)   && (state_q != S_GA))   req_a_d = 1'b0;
      if ((state_d == S_GB)   && (state_q != S_GB))   req_b_d = 1'b0;
      if ((state_d == S_WALK) && (state_q != S_WALK)) req_p_d = 1'b0;

      last_road_d = last_road_q;
      if ((state_d == S_ARA) && (state_q != S_ARA)) last_road_d = 1'b0;
      if ((state_d == S_ARB) && (state_q != S_ARB)) last_road_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_GA;
         timer_q     <= '0;
         req_a_q     <= 1'b0;
         req_b_q     <= 1'b0;
         req_p_q     <= 1'b0;
         last_road_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         req_a_q     <= req_a_d;
         req_b_q     <= req_b_d;
         req_p_q     <= req_p_d;
         last_road_q <= last_road_d;
      end
   end

   always_comb begin
      Ga    = (state_q == S_GA);
      Ya    = (state_q == S_YA);
      Ra    = !(Ga || Ya);
      Gb    = (state_q == S_GB);
      Yb    = (state_q == S_YB);
      Rb    = !(Gb || Yb);
      walk  = (state_q == S_WALK);
      phase = state_q;
   end

endmodule
